fifo_param: RTL and testbench
=============================

Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's 4-bit push/pop FIFO.
- Adds configurable data width and depth, an occupancy count, and programmable almost-full/almost-empty flags.
- Adds overflow/underflow error flags.
- Single clock domain; sits between a producer and a consumer that use push/pop strobes.

Parameters:
- DATA_W, 4, data word width in bits
- DEPTH, 8, number of entries; must be a power of two, >= 2
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- data_in  in  DATA_W  write data, sampled on an accepted push
- push  in  1  write request
- pop  in  1  read request
- data_out  out  DATA_W  registered read data
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set on push while full without pop
- underflow  out  1  sticky; set on pop while empty

Behaviour:
- Interface (already decided): one clock `clk`; reset port `reset` is synchronous and active-high.
- Reset values:
  - pointers = 0, count = 0, data_out = 0
  - fifo_empty = 1, fifo_full = 0
  - almost_empty = 1, almost_full = (AF_LEVEL == 0)
  - overflow = 0, underflow = 0
  - Storage contents are not reset.
- Accepted operations:
  - push_ok = push & (!fifo_full | pop)
  - pop_ok = pop & !fifo_empty
  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- Push: on push_ok, mem[wr_ptr] <= data_in and wr_ptr++.
- Pop: on pop_ok, data_out <= mem[rd_ptr] and rd_ptr++. One-cycle latency: data_out is valid the cycle after the pop edge and holds until the next pop_ok.
- Count: next count = count + push_ok - pop_ok. All flags are registered and derived from next count, so they are valid in the same cycle as count.
- Simultaneous push and pop:
  - Not full and not empty: both occur, count unchanged.
  - Full: both accepted; the push writes the slot freed by the pop. The read uses old memory contents, so there is no write-through hazard.
  - Empty: pop is rejected and underflow is set. The push is accepted; count = 1.
- Rejected operations:
  - Push while full without pop: dropped, overflow set, memory and pointers unchanged.
  - Pop while empty: data_out holds, underflow set.
- overflow and underflow are cleared only by reset.
- Reset mid-operation: reset has priority over push and pop in the same cycle, and all state returns to reset values.
- No state machine beyond the pointer/count registers.

Optional Feature:
- Macro: FIFO_PARAM_FWFT_EN
- Defined (first-word-fall-through):
  - data_out presents mem[rd_ptr] combinationally whenever !fifo_empty.
  - pop advances rd_ptr with zero-cycle read latency.
  - data_out = 0 when empty.
- Undefined: registered read with one-cycle latency, as specified above.
- Flag and count behaviour are identical in both modes.

Decomposition:
- Package fifo_param_pkg holds:
  - a function computing pointer width from depth
  - a localparam for the default DATA_W
  - an error-code typedef for {overflow, underflow}
- One sub-module, fifo_param_mem: a DEPTH x DATA_W storage array with a synchronous write port and a read port that is registered or combinational per FIFO_PARAM_FWFT_EN.
- Pointer/count/flag logic stays in the top module.

Test Plan:
- Reset, then push 0x2 and 0x4, then pop: data_out = 0x2 one cycle after the pop edge; count = 1; fifo_empty = 0.
- Push 8 words 0x0..0x7 (DEPTH = 8): fifo_full = 1 after the 8th edge; almost_full = 1 once count reaches 6.
- A 9th push of 0xF while full: overflow = 1; popping all 8 yields 0x0..0x7, with no 0xF present.
- Pop while empty: underflow = 1; data_out holds its last value; count stays 0.
- Fill to full, then push 0xA and pop together: count stays 8; the pop returns the oldest word. Continue the sequence: 0xA appears after the remaining 7 words, confirming pointer wrap-around.
- Assert reset with count = 5 and push = 1: next cycle count = 0, fifo_empty = 1, overflow = underflow = 0.
- Repeat the first and third scenarios with FIFO_PARAM_FWFT_EN defined: data_out = 0x2 immediately after the first push, before any pop.

Source files
------------

// File: rtl/fifo_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param_pkg
// Description : Shared definitions for the parametrised synchronous FIFO.
//               Holds the default data width, a pointer-width helper and
//               the packed {overflow, underflow} error-flag type.
// Config      : FIFO_PARAM_FWFT_EN selects first-word-fall-through reads in
//               the FIFO that imports this package (no effect here).
// Revision    : 1.0  initial release
// ============================================================================
package fifo_param_pkg;

  // Default word width, matching the previous 4-bit FIFO generation.
  localparam int unsigned DATA_W_DEFAULT = 4;

  // Sticky error flags, kept together so that reset and update logic
  // treat them as one register.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Pointer width for a power-of-two depth. Clamped to one bit so that a
  // degenerate depth still gives a legal vector width.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : fifo_param_pkg
`default_nettype wire

// File: rtl/fifo_param_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param_mem
// Description : DEPTH x DATA_W storage array for fifo_param. One synchronous
//               write port and one read port.
//               Read port, FIFO_PARAM_FWFT_EN undefined: registered, the word
//               at i_rd_addr is captured on an i_rd_en edge and held
//               otherwise; cleared by reset.
//               Read port, FIFO_PARAM_FWFT_EN defined: combinational view of
//               the word at i_rd_addr.
// Ports       : clk       in   clock, rising edge
//               reset     in   synchronous active-high reset (read register)
//               i_wr_en   in   write strobe
//               i_wr_addr in   write address
//               i_wr_data in   write data
//               i_rd_en   in   read strobe (registered mode only)
//               i_rd_addr in   read address
//               o_rd_data out  read data
// Config      : FIFO_PARAM_FWFT_EN
// Revision    : 1.0  initial release
// ============================================================================
module fifo_param_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  // Storage is deliberately not reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

`ifdef FIFO_PARAM_FWFT_EN
  // Zero-latency read; the read strobe and reset have no role here.
  assign o_rd_data = mem_q[i_rd_addr];

  logic unused_rd_ctrl;
  assign unused_rd_ctrl = &{1'b0, reset, i_rd_en};
`else
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Nonblocking write above means a same-edge write to i_rd_addr is not
  // seen here: the read returns the old contents.
  always_comb begin
    rd_data_d = rd_data_q;
    if (i_rd_en) begin
      rd_data_d = mem_q[i_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data = rd_data_q;
`endif

endmodule : fifo_param_mem
`default_nettype wire

// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param
// Description : Parametrised single-clock FIFO with occupancy count,
//               programmable almost-full/almost-empty flags and sticky
//               overflow/underflow error flags.
// Ports       : clk          in   clock, rising edge
//               reset        in   synchronous active-high reset
//               data_in      in   write data, taken on an accepted push
//               push         in   write request
//               pop          in   read request
//               data_out     out  read data
//               fifo_full    out  count == DEPTH
//               fifo_empty   out  count == 0
//               almost_full  out  count >= AF_LEVEL
//               almost_empty out  count <= AE_LEVEL
//               count        out  current occupancy
//               overflow     out  sticky: push while full without pop
//               underflow    out  sticky: pop while empty
// Config      : FIFO_PARAM_FWFT_EN -- when defined, data_out shows the head
//               word combinationally (0 while empty) and pop has zero read
//               latency; otherwise data_out is registered, one-cycle latency.
//               DEPTH must be a power of two and at least 2.
// Revision    : 1.0  initial release
// ============================================================================
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   push,
  input  logic                   pop,
  output logic [DATA_W-1:0]      data_out,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] C_DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] C_AE_CNT    = CNT_W'(AE_LEVEL);
  localparam logic             C_AF_RESET  = (AF_LEVEL == 0);

  logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              full_d, full_q;
  logic              empty_d, empty_q;
  logic              af_d, af_q;
  logic              ae_d, ae_q;
  fifo_err_t         err_d, err_q;

  logic              push_ok;
  logic              pop_ok;
  logic [DATA_W-1:0] mem_rd_data;

  // A push while full is still accepted when a pop frees a slot in the
  // same cycle; a pop while empty is always refused, even alongside a push.
  always_comb begin
    push_ok = push & (~full_q | pop);
    pop_ok  = pop & ~empty_q;

    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

    // Flags follow the next count so they line up with count itself.
    full_d  = (count_d == C_DEPTH_CNT);
    empty_d = (count_d == '0);
    af_d    = (count_d >= C_AF_CNT);
    ae_d    = (count_d <= C_AE_CNT);

    err_d           = err_q;
    err_d.overflow  = err_q.overflow  | (push & full_q & ~pop);
    err_d.underflow = err_q.underflow | (pop & empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= C_AF_RESET;
      ae_q     <= 1'b1;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      err_q    <= err_d;
    end
  end

  fifo_param_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (push_ok),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (data_in),
    .i_rd_en   (pop_ok),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (mem_rd_data)
  );

`ifdef FIFO_PARAM_FWFT_EN
  // Stale array contents must not leak out while the FIFO is empty.
  assign data_out = empty_q ? '0 : mem_rd_data;
`else
  assign data_out = mem_rd_data;
`endif

  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule : fifo_param
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_param
// Description : Directed self-checking bench for fifo_param (DATA_W=4,
//               DEPTH=8, AF_LEVEL=6, AE_LEVEL=2). Data expectations follow
//               FIFO_PARAM_FWFT_EN when it is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_param;

  logic       clk;
  logic       reset;
  logic [3:0] data_in;
  logic       push;
  logic       pop;
  logic [3:0] data_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int n_tests;
  int n_fail;

  fifo_param #(
    .DATA_W   (4),
    .DEPTH    (8),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .push         (push),
    .pop          (pop),
    .data_out     (data_out),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs are stable #1 after the edge.
  task automatic cyc(input logic p, input logic q, input logic [3:0] d);
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 4'h0);
    reset = 1'b0;
  endtask

  // Pop one word and check it, whichever read mode is built.
  task automatic pop_check(input string tag, input int exp);
`ifdef FIFO_PARAM_FWFT_EN
    check(tag, int'(data_out), exp);
    cyc(1'b0, 1'b1, 4'h0);
`else
    cyc(1'b0, 1'b1, 4'h0);
    check(tag, int'(data_out), exp);
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = 4'h0;
    #1;

    // Reset state
    do_reset();
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_full", int'(fifo_full), 0);
    check("rst_ae", int'(almost_empty), 1);
    check("rst_af", int'(almost_full), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_unf", int'(underflow), 0);
    check("rst_dout", int'(data_out), 0);

    // Push 2, 4 then pop
    cyc(1'b1, 1'b0, 4'h2);
`ifdef FIFO_PARAM_FWFT_EN
    check("fwft_first", int'(data_out), 2);
`endif
    cyc(1'b1, 1'b0, 4'h4);
    check("s1_count2", int'(count), 2);
    pop_check("s1_pop0", 2);
    check("s1_count1", int'(count), 1);
    check("s1_empty", int'(fifo_empty), 0);
`ifdef FIFO_PARAM_FWFT_EN
    check("fwft_next", int'(data_out), 4);
`endif
    pop_check("s1_pop1", 4);
    check("s1_count0", int'(count), 0);
    check("s1_empty0", int'(fifo_empty), 1);

    // Fill with 0..7 checking thresholds as count climbs
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 4'(i));
      check($sformatf("fill_count%0d", i), int'(count), i + 1);
      check($sformatf("fill_af%0d", i), int'(almost_full), (i + 1 >= 6) ? 1 : 0);
      check($sformatf("fill_ae%0d", i), int'(almost_empty), (i + 1 <= 2) ? 1 : 0);
      check($sformatf("fill_full%0d", i), int'(fifo_full), (i == 7) ? 1 : 0);
    end
    // 9th push dropped
    cyc(1'b1, 1'b0, 4'hF);
    check("ovf_set", int'(overflow), 1);
    check("ovf_count", int'(count), 8);
    for (int i = 0; i < 8; i++) begin
      pop_check($sformatf("drain%0d", i), i);
    end
    check("drain_empty", int'(fifo_empty), 1);
    check("ovf_sticky", int'(overflow), 1);

    // Pop while empty
    cyc(1'b0, 1'b1, 4'h0);
    check("unf_set", int'(underflow), 1);
    check("unf_count", int'(count), 0);
`ifdef FIFO_PARAM_FWFT_EN
    check("unf_dout", int'(data_out), 0);
`else
    check("unf_dout", int'(data_out), 7);
`endif

    // Full + simultaneous push/pop, then pointer wrap
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 4'(i));
    end
`ifdef FIFO_PARAM_FWFT_EN
    check("fp_head", int'(data_out), 1);
    cyc(1'b1, 1'b1, 4'hA);
`else
    cyc(1'b1, 1'b1, 4'hA);
    check("fp_head", int'(data_out), 1);
`endif
    check("fp_count", int'(count), 8);
    check("fp_full", int'(fifo_full), 1);
    check("fp_ovf", int'(overflow), 0);
    for (int i = 2; i <= 8; i++) begin
      pop_check($sformatf("wrap%0d", i), i);
    end
    pop_check("wrap_a", 10);
    check("wrap_empty", int'(fifo_empty), 1);

    // Push+pop on empty, then reset under load
    do_reset();
    cyc(1'b1, 1'b1, 4'h3);
    check("pe_count", int'(count), 1);
    check("pe_unf", int'(underflow), 1);
    check("pe_empty", int'(fifo_empty), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 4'(i + 5));
    end
    check("pre_rst_count", int'(count), 5);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 4'h9);
    reset = 1'b0;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_empty", int'(fifo_empty), 1);
    check("mid_rst_ovf", int'(overflow), 0);
    check("mid_rst_unf", int'(underflow), 0);
    check("mid_rst_dout", int'(data_out), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_param
`default_nettype wire
